// File: rtl/dma_arb_pkg.sv
// Shared types for the DMA channel arbiter.
// State encoding and channel-ID width used by the FSM and the picker.
package dma_arb_pkg;

   localparam int CH_ID_W = 6;

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      ISSUE,
      WAIT_DONE
   } arb_state_t;

endpackage

// File: rtl/rr_prio_select.sv
// Combinational highest-priority picker.
// Ties between equal priorities are broken round-robin after last_grant.
module rr_prio_select
   import dma_arb_pkg::*;
#(
   parameter int NUM_CHANNELS = 32,
   parameter int PRIO_WIDTH   = 4
) (
   input  logic [NUM_CHANNELS-1:0]                 valid,
   input  logic [NUM_CHANNELS-1:0][PRIO_WIDTH-1:0] prio,
   input  logic [CH_ID_W-1:0]                      last_grant,
   output logic [CH_ID_W-1:0]                      grant_id,
   output logic                                    any_valid
);

   logic [PRIO_WIDTH-1:0] max_prio;
   logic                  found;
   int                    idx;

   always_comb begin
      max_prio  = '0;
      any_valid = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (valid[i]) begin
            any_valid = 1'b1;
            if (prio[i] > max_prio) begin
               max_prio = prio[i];
            end
         end
      end
   end

   // Walk from last_grant+1 with wrap; first max-priority hit wins.
   always_comb begin
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         idx = int'(last_grant) + 1 + k;
         if (idx >= NUM_CHANNELS) begin
            idx = idx - NUM_CHANNELS;
         end
         if (idx >= NUM_CHANNELS) begin
            idx = idx - NUM_CHANNELS;
         end
         if (!found && valid[idx] &&
             (prio[idx] == max_prio)) begin
            found    = 1'b1;
            grant_id = CH_ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/dma_ch_arbiter.sv
// DMA channel scheduler: channel table, burst FSM, completion reporting.
// Issues one burst at a time for the highest-priority pending channel.
module dma_ch_arbiter
   import dma_arb_pkg::*;
#(
   parameter int NUM_CHANNELS = 32,
   parameter int MAX_BURST    = 16,
   parameter int PRIO_WIDTH   = 4
) (
   input  logic                  AXI_aclk,
   input  logic                  AXI_aresetn,
   input  logic                  arbSample,
   input  logic [CH_ID_W-1:0]    arbCurrentChannelSample,
   input  logic [PRIO_WIDTH-1:0] arbChannelPriority,
   input  logic [31:0]           arbChannelTransferSize,
   input  logic                  arbitrate,
   output logic                  burst_valid,
   input  logic                  burst_ready,
   output logic [CH_ID_W-1:0]    burst_ch_id,
   output logic [7:0]            burst_len,
   input  logic                  burst_done,
   output logic                  ch_done,
   output logic [CH_ID_W-1:0]    ch_id,
   output logic                  arbWriteTransactionsDone
);

   arb_state_t state_q;

   logic [NUM_CHANNELS-1:0]                 valid_q;
   logic [NUM_CHANNELS-1:0][PRIO_WIDTH-1:0] prio_q;
   logic [NUM_CHANNELS-1:0][31:0]           rem_q;

   logic [CH_ID_W-1:0] last_grant_q;
   logic [CH_ID_W-1:0] sel_id_q;
   logic [8:0]         sel_beats_q;

   logic               burst_valid_q;
   logic [CH_ID_W-1:0] burst_ch_id_q;
   logic [7:0]         burst_len_q;
   logic               ch_done_q;
   logic [CH_ID_W-1:0] ch_id_q;

   logic [CH_ID_W-1:0] grant_id;
   logic               any_valid;
   logic [31:0]        grant_rem;
   logic [31:0]        sel_rem;
   logic [8:0]         grant_beats;
   logic [31:0]        sel_left;
   logic               sample_hit;

   rr_prio_select #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .PRIO_WIDTH   (PRIO_WIDTH)
   ) u_sel (
      .valid      (valid_q),
      .prio       (prio_q),
      .last_grant (last_grant_q),
      .grant_id   (grant_id),
      .any_valid  (any_valid)
   );

   always_comb begin
      grant_rem = '0;
      sel_rem   = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (grant_id == CH_ID_W'(i)) begin
            grant_rem = rem_q[i];
         end
         if (sel_id_q == CH_ID_W'(i)) begin
            sel_rem = rem_q[i];
         end
      end
   end

   assign grant_beats =
      (grant_rem > 32'(MAX_BURST)) ?
      9'(MAX_BURST) : grant_rem[8:0];

   // Saturate so a mid-run reload to a smaller size cannot underflow.
   assign sel_left =
      (sel_rem > {23'b0, sel_beats_q}) ?
      sel_rem - {23'b0, sel_beats_q} : '0;

   assign sample_hit =
      arbSample &&
      (arbCurrentChannelSample == sel_id_q);

   always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
      if (!AXI_aresetn) begin
         state_q       <= IDLE;
         valid_q       <= '0;
         prio_q        <= '0;
         rem_q         <= '0;
         last_grant_q  <= CH_ID_W'(NUM_CHANNELS - 1);
         sel_id_q      <= '0;
         sel_beats_q   <= '0;
         burst_valid_q <= 1'b0;
         burst_ch_id_q <= '0;
         burst_len_q   <= '0;
         ch_done_q     <= 1'b0;
         ch_id_q       <= '0;
      end else begin
         ch_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (arbitrate) begin
                  state_q <= SELECT;
               end
            end
            SELECT: begin
               if (!any_valid) begin
                  state_q <= IDLE;
               end else begin
                  sel_id_q      <= grant_id;
                  sel_beats_q   <= grant_beats;
                  last_grant_q  <= grant_id;
                  burst_valid_q <= 1'b1;
                  burst_ch_id_q <= grant_id;
                  burst_len_q   <= 8'(grant_beats - 9'd1);
                  state_q       <= ISSUE;
               end
            end
            ISSUE: begin
               if (burst_ready) begin
                  burst_valid_q <= 1'b0;
                  state_q       <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (burst_done) begin
                  for (int i = 0; i < NUM_CHANNELS; i++) begin
                     if (sel_id_q == CH_ID_W'(i)) begin
                        rem_q[i] <= sel_left;
                        if (sel_left == '0) begin
                           valid_q[i] <= 1'b0;
                        end
                     end
                  end
                  if ((sel_left == '0) && !sample_hit) begin
                     ch_done_q <= 1'b1;
                     ch_id_q   <= sel_id_q;
                  end
                  state_q <= SELECT;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Placed last so a same-cycle sample overrides the decrement.
         if (arbSample) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
               if (arbCurrentChannelSample == CH_ID_W'(i)) begin
                  if (arbChannelTransferSize != '0) begin
                     valid_q[i] <= 1'b1;
                     prio_q[i]  <= arbChannelPriority;
                     rem_q[i]   <= arbChannelTransferSize;
                  end else begin
                     valid_q[i] <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign burst_valid = burst_valid_q;
   assign burst_ch_id = burst_ch_id_q;
   assign burst_len   = burst_len_q;
   assign ch_done     = ch_done_q;
   assign ch_id       = ch_id_q;

   // Decoded from registered state so the empty-table pulse lands in SELECT.
   assign arbWriteTransactionsDone =
      (state_q == SELECT) && !any_valid;

endmodule

// File: doc/dma_ch_arbiter.md
# dma_ch_arbiter

Channel scheduler for the DMA read/write engine. Channel entries arrive from the channel-configuration reader through the sample interface: ID, priority and transfer size in beats. On the `arbitrate` pulse the block repeatedly picks the highest-priority pending channel and issues one AXI burst request for it to the transfer engine. It tracks the remaining beats per channel and reports per-channel completion (`ch_done`/`ch_id`) and global completion (`arbWriteTransactionsDone`) back to the configuration reader.

## Interface
Parameters:
- `NUM_CHANNELS`, default 32: number of channel table entries; legal IDs are 0..NUM_CHANNELS-1.
- `MAX_BURST`, default 16: maximum beats per issued burst, legal range 1..256.
- `PRIO_WIDTH`, default 4: priority field width; a larger value means higher priority.

Ports:
- `AXI_aclk` in 1: single clock; all logic is posedge.
- `AXI_aresetn` in 1: asynchronous, active-low reset.
- `arbSample` in 1: loads one channel entry this cycle.
- `arbCurrentChannelSample` in 6: ID of the entry being loaded.
- `arbChannelPriority` in PRIO_WIDTH: priority of the entry being loaded.
- `arbChannelTransferSize` in 32: total beats for the entry being loaded.
- `arbitrate` in 1: one-cycle pulse that starts scheduling.
- `burst_valid` out 1: burst request valid.
- `burst_ready` in 1: engine accepts the burst request.
- `burst_ch_id` out 6: channel ID of the burst.
- `burst_len` out 8: AXI LEN encoding, i.e. beats-1.
- `burst_done` in 1: one-cycle pulse; the last issued burst has completed (write response received).
- `ch_done` out 1: one-cycle pulse; a channel is finished.
- `ch_id` out 6: ID of the finished channel; valid while `ch_done` is high.
- `arbWriteTransactionsDone` out 1: one-cycle pulse; no pending channels remain.

## Operation
- Channel table: per entry `valid`, `prio`, and `remaining` (32 bits).
- `arbSample` with ID < NUM_CHANNELS and size > 0: write the entry and set `valid`.
  - Size 0 clears `valid`.
  - ID >= NUM_CHANNELS is ignored.
  - Samples are accepted in every state, so channels can be added mid-run.
- FSM states, `arb_state_t`: IDLE, SELECT, ISSUE, WAIT_DONE.
- **IDLE**: `arbitrate` moves to SELECT. `arbitrate` in any other state is ignored.
- **SELECT** (1 cycle):
  - No valid entry: pulse `arbWriteTransactionsDone` and go to IDLE.
  - Otherwise pick the maximum `prio` among valid entries. Ties go round-robin, searching from `last_grant+1` upward and wrapping.
  - Register `sel_id` and `sel_beats = min(remaining, MAX_BURST)`, set `last_grant = sel_id`, then go to ISSUE.
- **ISSUE**:
  - `burst_valid` = 1; `burst_ch_id` = `sel_id`; `burst_len` = `sel_beats`-1.
  - These outputs stay stable until `burst_valid & burst_ready`, then go to WAIT_DONE.
- **WAIT_DONE**: on `burst_done`:
  - `remaining[sel_id]` -= `sel_beats`.
  - If the result is 0: clear `valid`, pulse `ch_done` with `ch_id = sel_id`.
  - Go to SELECT.
- Preemption happens only at burst granularity. A newly sampled higher-priority channel wins at the next SELECT. Strict priority: lower priorities are served only when no higher-priority entry is valid.
- `arbSample` to `sel_id` in the same cycle as `burst_done`: the sample wins. The entry is reloaded, the decrement is discarded, and no `ch_done` is issued.
- `burst_done` outside WAIT_DONE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; all `valid` bits 0; `last_grant` = NUM_CHANNELS-1, so channel 0 wins the first tie.
- `arbitrate` at cycle N: SELECT at N+1, `burst_valid` high at N+2.
- `burst_done` at cycle M: `ch_done` registered high at M+1, SELECT at M+1, next `burst_valid` at M+2.
- The `arbWriteTransactionsDone` pulse leaves SELECT; the block is in IDLE the cycle after.
- A sample written at cycle K is visible to a SELECT at K+1 or later.
- Reset asserted mid-burst: everything returns to reset values immediately. No `ch_done` is issued for the aborted channel.

## Structure
- Package `dma_arb_pkg`: the `arb_state_t` enum and a `CH_ID_W = 6` constant.
- Sub-module `rr_prio_select`: combinational. Inputs `valid`, `prio` array and `last_grant`; outputs `grant_id` and `any_valid`.
- Top level: FSM, channel table and output registers. Target 200-300 lines.

## Test plan
- Single channel: ID 3, prio 2, size 40, then `arbitrate`. Expect bursts with `burst_len` 15, 15, 7, then `ch_done` with `ch_id` = 3, then `arbWriteTransactionsDone`.
- Priority: ID 1 prio 1 size 16; ID 5 prio 7 size 32. Expect the burst order 5, 5, 1 and `ch_done` for 5 before 1.
- Round-robin: IDs 0, 2, 4 all prio 3, size 32 each. Expect burst IDs 0, 2, 4, 0, 2, 4.
- Mid-run add: ID 0 prio 1 size 64 running; sample ID 9 prio 5 size 16 during WAIT_DONE. Expect the next burst ID to be 9.
- Backpressure: hold `burst_ready` low for 5 cycles. `burst_ch_id` and `burst_len` must stay stable; no duplicate grants.
- Edge cases:
  - Size 0 sample creates no burst.
  - `arbitrate` with an empty table gives `arbWriteTransactionsDone` at cycle N+1.
  - Reset during WAIT_DONE gives all outputs 0.
